// File: rtl/store_write_buffer.sv
// In-order store FIFO that drains into the 64 x 128-bit line memory and forwards buffered data to loads.
// Each drain holds the head on mem_* for WRITE_LATENCY cycles, then commits with mem_we/inv_valid.
module store_write_buffer #(
    parameter int DEPTH         = 4,
    parameter int WRITE_LATENCY = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemWrite,
    input  logic [31:0] address,
    input  logic [31:0] datafrmreg,
    output logic        full,
    output logic        drop,
    output logic        mem_we,
    output logic [5:0]  mem_line,
    output logic [1:0]  mem_word,
    output logic [31:0] mem_wdata,
    output logic        inv_valid,
    output logic [2:0]  inv_index,
    output logic [26:0] inv_tag,
    input  logic [31:0] rd_addr,
    output logic        rd_hit,
    output logic [31:0] rd_data,
    output logic        empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = (WRITE_LATENCY > 1) ? $clog2(WRITE_LATENCY) : 1;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [PW:0]   cnt_t;
    typedef enum logic [1:0] {IDLE, WAIT, COMMIT} state_t;

    logic [31:0] addr_q [DEPTH];
    logic [31:0] data_q [DEPTH];
    ptr_t        head, tail, youngest, fidx;
    cnt_t        count, count_nxt;
    state_t      state, state_nxt;
    logic [LW-1:0] lat_cnt, lat_nxt;
    logic        push, pop, coalesce;
    logic [31:0] head_addr, head_data;

    assign youngest = tail - ptr_t'(1);
    assign push     = MemWrite && !full;
    assign pop      = (state == COMMIT);
    // The head is frozen on mem_* once draining starts, so it must not be rewritten.
    assign coalesce = push && (count != '0) && (addr_q[youngest] == address)
                      && !((youngest == head) && (state != IDLE));

    always_comb begin
        count_nxt = count;
        if (push && !coalesce) count_nxt = count_nxt + cnt_t'(1);
        if (pop)               count_nxt = count_nxt - cnt_t'(1);
    end

    always_comb begin
        state_nxt = state;
        lat_nxt   = lat_cnt;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    state_nxt = WAIT;
                    lat_nxt   = '0;
                end
            end
            WAIT: begin
                lat_nxt = lat_cnt + LW'(1);
                if (lat_cnt == LW'(WRITE_LATENCY - 1)) state_nxt = COMMIT;
            end
            COMMIT: begin
                lat_nxt   = '0;
                state_nxt = (count_nxt != '0) ? WAIT : IDLE;
            end
            default: begin
                state_nxt = IDLE;
                lat_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            lat_cnt <= '0;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            full    <= 1'b0;
            empty   <= 1'b1;
            drop    <= 1'b0;
        end else begin
            state   <= state_nxt;
            lat_cnt <= lat_nxt;
            count   <= count_nxt;
            full    <= (count_nxt == cnt_t'(DEPTH));
            empty   <= (count_nxt == '0);
            drop    <= MemWrite && full;
            if (push && !coalesce) tail <= tail + ptr_t'(1);
            if (pop)               head <= head + ptr_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            if (coalesce) begin
                data_q[youngest] <= datafrmreg;
            end else begin
                addr_q[tail] <= address;
                data_q[tail] <= datafrmreg;
            end
        end
    end

    assign head_addr = (count != '0) ? addr_q[head] : '0;
    assign head_data = (count != '0) ? data_q[head] : '0;
    assign mem_we    = pop;
    assign inv_valid = pop;
    assign mem_line  = head_addr[7:2];
    assign mem_word  = head_addr[1:0];
    assign mem_wdata = head_data;
    assign inv_index = head_addr[4:2];
    assign inv_tag   = head_addr[31:5];

    // Walk oldest to youngest so the last match (youngest) wins.
    always_comb begin
        rd_hit  = 1'b0;
        rd_data = '0;
        fidx    = head;
        for (int i = 0; i < DEPTH; i++) begin
            fidx = head + ptr_t'(i);
            if ((cnt_t'(i) < count) && (addr_q[fidx] == rd_addr)) begin
                rd_hit  = 1'b1;
                rd_data = data_q[fidx];
            end
        end
    end
endmodule

// File: tb/tb_store_write_buffer.sv
// Scenario bench for store_write_buffer: expected commits are queued as stores are driven
// and popped by a commit monitor; each scenario task also checks timing and flags inline.
module tb_store_write_buffer;
    logic        clk = 1'b0;
    logic        rst, MemWrite;
    logic [31:0] address, datafrmreg, rd_addr;
    logic        full, drop, mem_we, inv_valid, rd_hit, empty;
    logic [5:0]  mem_line;
    logic [1:0]  mem_word;
    logic [31:0] mem_wdata, rd_data;
    logic [2:0]  inv_index;
    logic [26:0] inv_tag;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } st_t;

    st_t         sb[$];
    st_t         mon_e;
    logic [70:0] mon_got, mon_exp;
    int          total = 0;
    int          bad   = 0;

    store_write_buffer #(.DEPTH(4), .WRITE_LATENCY(3)) dut (
        .clk(clk), .rst(rst), .MemWrite(MemWrite), .address(address), .datafrmreg(datafrmreg),
        .full(full), .drop(drop), .mem_we(mem_we), .mem_line(mem_line), .mem_word(mem_word),
        .mem_wdata(mem_wdata), .inv_valid(inv_valid), .inv_index(inv_index), .inv_tag(inv_tag),
        .rd_addr(rd_addr), .rd_hit(rd_hit), .rd_data(rd_data), .empty(empty)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL commit_unexpected: got line=%0d word=%0d data=%h, required no commit",
                         mem_line, mem_word, mem_wdata);
            end else begin
                mon_e   = sb.pop_front();
                mon_exp = {mon_e.a[7:2], mon_e.a[1:0], mon_e.d, 1'b1, mon_e.a[4:2], mon_e.a[31:5]};
                mon_got = {mem_line, mem_word, mem_wdata, inv_valid, inv_index, inv_tag};
                if (mon_got !== mon_exp) begin
                    bad++;
                    $display("FAIL commit_fields: got %h, required %h", mon_got, mon_exp);
                end
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input bit exp_c);
        MemWrite   = 1'b1;
        address    = a;
        datafrmreg = d;
        if (exp_c) sb.push_back({a, d});
        step();
        MemWrite = 1'b0;
    endtask

    task automatic wait_drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (empty && !mem_we && sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; MemWrite = 1'b0; address = '0; datafrmreg = '0; rd_addr = '0;
        step();
        step();
        total++; if (full !== 1'b0)  begin bad++; $display("FAIL reset_full: got %b, required 0", full); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty: got %b, required 1", empty); end
        total++; if ({drop, mem_we, inv_valid} !== 3'b000)
            begin bad++; $display("FAIL reset_strobes: got %b, required 000", {drop, mem_we, inv_valid}); end
        total++; if ({mem_line, mem_word, mem_wdata, inv_index, inv_tag} !== '0)
            begin bad++; $display("FAIL reset_mem_bus: got line=%0d data=%h, required 0", mem_line, mem_wdata); end
        total++; if ({rd_hit, rd_data} !== '0)
            begin bad++; $display("FAIL reset_fwd: got hit=%b data=%h, required 0", rd_hit, rd_data); end
    endtask

    task automatic test_single;
        rst = 1'b0;
        drive(32'h0000_0004, 32'hDEAD_BEEF, 1'b1);
        total++; if (empty !== 1'b0) begin bad++; $display("FAIL single_empty_c1: got %b, required 0", empty); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL single_we_c1: got %b, required 0", mem_we); end
        for (int c = 2; c <= 4; c++) begin
            step();
            total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL single_we_c%0d: got %b, required 0", c, mem_we); end
        end
        step();
        total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL single_we_c5: got %b, required 1", mem_we); end
        total++; if ({mem_line, mem_word, inv_index, inv_tag} !== {6'd1, 2'd0, 3'd1, 27'd0})
            begin bad++; $display("FAIL single_fields: got line=%0d word=%0d idx=%0d tag=%h, required 1 0 1 0",
                                  mem_line, mem_word, inv_index, inv_tag); end
        step();
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL single_empty_c6: got %b, required 1", empty); end
    endtask

    task automatic test_full_drop;
        bit ok;
        drive(32'h10, 32'h101, 1'b1);
        drive(32'h14, 32'h102, 1'b1);
        drive(32'h18, 32'h103, 1'b1);
        drive(32'h1C, 32'h104, 1'b1);
        total++; if (full !== 1'b1) begin bad++; $display("FAIL full_after_4: got %b, required 1", full); end
        drive(32'h20, 32'hBAD, 1'b0);
        total++; if (drop !== 1'b1) begin bad++; $display("FAIL drop_pulse: got %b, required 1", drop); end
        total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL full_first_commit: got %b, required 1", mem_we); end
        for (int i = 1; i <= 12; i++) begin
            step();
            total++; if (mem_we !== ((i % 4) == 0))
                begin bad++; $display("FAIL commit_spacing_%0d: got %b, required %b", i, mem_we, (i % 4) == 0); end
            if (i == 1) begin
                total++; if ({drop, full} !== 2'b00)
                    begin bad++; $display("FAIL drop_full_clear: got %b, required 00", {drop, full}); end
            end
        end
        wait_drain(ok);
        total++; if (!ok) begin bad++; $display("FAIL full_drain: got pending=%0d, required 0", sb.size()); end
    endtask

    task automatic test_coalesce;
        bit ok;
        drive(32'h3C, 32'h05, 1'b1);
        drive(32'h40, 32'h11, 1'b0);
        drive(32'h40, 32'h22, 1'b1);
        wait_drain(ok);
        total++; if (!ok) begin bad++; $display("FAIL coalesce_drain: got pending=%0d, required 0", sb.size()); end
        drive(32'h40, 32'h11, 1'b1);
        step();
        drive(32'h40, 32'h22, 1'b1);
        wait_drain(ok);
        total++; if (!ok) begin bad++; $display("FAIL head_nocoalesce_drain: got pending=%0d, required 0", sb.size()); end
    endtask

    task automatic test_forward;
        bit ok;
        drive(32'h80, 32'hA, 1'b1);
        step();
        MemWrite = 1'b1; address = 32'h80; datafrmreg = 32'hB; sb.push_back({32'h80, 32'hB});
        rd_addr = 32'h80;
        #1;
        total++; if ({rd_hit, rd_data} !== {1'b1, 32'hA})
            begin bad++; $display("FAIL fwd_same_cycle_push: got hit=%b data=%h, required 1 a", rd_hit, rd_data); end
        step();
        MemWrite = 1'b0;
        total++; if ({rd_hit, rd_data} !== {1'b1, 32'hB})
            begin bad++; $display("FAIL fwd_youngest: got hit=%b data=%h, required 1 b", rd_hit, rd_data); end
        rd_addr = 32'h84;
        #1;
        total++; if ({rd_hit, rd_data} !== {1'b0, 32'h0})
            begin bad++; $display("FAIL fwd_miss: got hit=%b data=%h, required 0 0", rd_hit, rd_data); end
        rd_addr = 32'h80;
        step();
        step();
        total++; if ({mem_we, rd_hit, rd_data} !== {1'b1, 1'b1, 32'hB})
            begin bad++; $display("FAIL fwd_during_commit: got we=%b hit=%b data=%h, required 1 1 b", mem_we, rd_hit, rd_data); end
        wait_drain(ok);
        total++; if (!ok) begin bad++; $display("FAIL fwd_drain: got pending=%0d, required 0", sb.size()); end
        total++; if ({rd_hit, rd_data} !== {1'b0, 32'h0})
            begin bad++; $display("FAIL fwd_after_drain: got hit=%b data=%h, required 0 0", rd_hit, rd_data); end
    endtask

    task automatic test_reset_midflight;
        int seen;
        drive(32'hC0, 32'h1, 1'b0);
        drive(32'hC4, 32'h2, 1'b0);
        drive(32'hC8, 32'h3, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if ({empty, full, mem_we} !== 3'b100)
            begin bad++; $display("FAIL midreset_flags: got empty/full/we=%b, required 100", {empty, full, mem_we}); end
        total++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL midreset_wdata: got %h, required 0", mem_wdata); end
        seen = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (mem_we) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL midreset_commits: got %0d, required 0", seen); end
    endtask

    task automatic test_push_on_commit;
        bit ok;
        drive(32'h100, 32'h61, 1'b1);
        drive(32'h104, 32'h62, 1'b1);
        drive(32'h108, 32'h63, 1'b1);
        step();
        step();
        total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL poc_commit_cycle: got %b, required 1", mem_we); end
        drive(32'h10C, 32'h64, 1'b1);
        total++; if ({full, empty} !== 2'b00)
            begin bad++; $display("FAIL poc_count_held: got full/empty=%b, required 00", {full, empty}); end
        drive(32'h110, 32'h65, 1'b1);
        total++; if ({full, drop} !== 2'b10)
            begin bad++; $display("FAIL poc_fill_to_full: got full/drop=%b, required 10", {full, drop}); end
        wait_drain(ok);
        total++; if (!ok) begin bad++; $display("FAIL poc_drain: got pending=%0d, required 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full_drop();
        test_coalesce();
        test_forward();
        test_reset_midflight();
        test_push_on_commit();
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
